// File: rtl/niosii_sysinfo.sv
// niosii_sysinfo: Avalon-MM system-information slave for the Nios II data master.
// It returns a constant system ID and build timestamp. It also exposes live uptime
// state: a free-running cycle counter, a seconds counter, a scratch register and
// a control register (CLEAR / FREEZE). The read path is registered, with a fixed
// read latency of 1.
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        synchronous active-low reset
//   address[2:0]   word address
//   read, write    single-cycle access strobes
//   writedata[31:0]
//   readdata[31:0] registered read data, holds between reads
//   readdatavalid  one cycle after each accepted read
//
// Register map:
//   0 SYSTEM_ID       1 TIMESTAMP       2 cycle[31:0] (snapshots high half)
//   3 hi_snap         4 seconds         5 scratch (RW)
//   6 control (RW)    7 CLOCK_HZ
module niosii_sysinfo #(
  parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter int unsigned CLOCK_HZ    = 50000000,
  parameter int unsigned CYCLE_WIDTH = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  typedef enum logic [2:0] {
    REG_ID      = 3'd0,
    REG_STAMP   = 3'd1,
    REG_CYC_LO  = 3'd2,
    REG_CYC_HI  = 3'd3,
    REG_SECONDS = 3'd4,
    REG_SCRATCH = 3'd5,
    REG_CONTROL = 3'd6,
    REG_CLK_HZ  = 3'd7
  } reg_addr_t;

  localparam int unsigned HI_W      = CYCLE_WIDTH - 32;
  localparam logic [31:0] PRESC_MAX = 32'(CLOCK_HZ - 1);
  localparam logic [CYCLE_WIDTH-1:0] CYC_ONE = {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};

  logic [CYCLE_WIDTH-1:0] cycle;
  logic [31:0]            presc;
  logic [31:0]            seconds;
  logic [HI_W-1:0]        hi_snap;
  logic [31:0]            scratch;
  logic                   freeze;

  logic                   clear;
  logic                   wr_scratch;
  logic                   wr_control;
  logic                   rd_lo;
  logic [31:0]            rd_mux;

  always_comb begin
    wr_scratch = write && (address == REG_SCRATCH);
    wr_control = write && (address == REG_CONTROL);
    clear      = wr_control && writedata[0];
    rd_lo      = read && (address == REG_CYC_LO);
  end

  // The read mux sees the current (pre-edge) state. A read on the same edge as
  // a write or an increment therefore returns the old value.
  always_comb begin
    rd_mux = '0;
    case (address)
      REG_ID:      rd_mux = SYSTEM_ID;
      REG_STAMP:   rd_mux = TIMESTAMP;
      REG_CYC_LO:  rd_mux = cycle[31:0];
      REG_CYC_HI:  rd_mux = 32'(hi_snap);
      REG_SECONDS: rd_mux = seconds;
      REG_SCRATCH: rd_mux = scratch;
      REG_CONTROL: rd_mux = {30'b0, freeze, 1'b0};
      REG_CLK_HZ:  rd_mux = 32'(CLOCK_HZ);
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      scratch       <= '0;
      freeze        <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read)       readdata <= rd_mux;
      if (wr_scratch) scratch  <= writedata;
      if (wr_control) freeze   <= writedata[1];
    end
  end

  // CLEAR takes priority over both the running increment and an address-2
  // snapshot on the same edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cycle   <= '0;
      presc   <= '0;
      seconds <= '0;
      hi_snap <= '0;
    end else if (clear) begin
      cycle   <= '0;
      presc   <= '0;
      seconds <= '0;
      hi_snap <= '0;
    end else begin
      if (!freeze) begin
        cycle <= cycle + CYC_ONE;
        if (presc == PRESC_MAX) begin
          presc   <= '0;
          seconds <= seconds + 32'd1;
        end else begin
          presc <= presc + 32'd1;
        end
      end
      if (rd_lo) hi_snap <= cycle[CYCLE_WIDTH-1:32];
    end
  end

endmodule
